// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes RX, detects a start edge, samples each bit
// at mid-period and presents the assembled byte with a sticky rdy flag.
module uart_rx #(
  parameter int BAUD_RATE = 19200,
  parameter int CLK_RATE  = 50_000_000,
  parameter int DIV_NUM   = CLK_RATE / BAUD_RATE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frame_err
);

  localparam logic [11:0] HALF_LOAD = 12'(DIV_NUM / 2);
  localparam logic [11:0] BIT_LOAD  = 12'(DIV_NUM - 1);

  typedef enum logic {
    IDLE,
    RECEIVE
  } state_t;

  state_t      state, state_nxt;
  logic        rx_meta, rx_sync, rx_hist;
  logic [1:0]  warm;
  logic        armed;
  logic [11:0] baud_cnt;
  logic [3:0]  bit_cnt;
  logic [7:0]  shift;
  logic        start_det;
  logic        sample;
  logic        frame_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_hist <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_hist <= rx_sync;
    end
  end

  // The chain resets to 1, so a line held low across reset would look like a
  // falling edge; start detection waits until the chain holds real samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm <= '0;
    end else if (warm != 2'd3) begin
      warm <= warm + 2'd1;
    end
  end

  assign armed = (warm == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    start_det  = 1'b0;
    sample     = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (armed && rx_hist && !rx_sync) begin
          start_det = 1'b1;
          state_nxt = RECEIVE;
        end
      end
      RECEIVE: begin
        if (baud_cnt == '0) begin
          sample = 1'b1;
          if (bit_cnt == 4'd0 && rx_sync) begin
            state_nxt = IDLE;
          end else if (bit_cnt == 4'd9) begin
            frame_done = 1'b1;
            state_nxt  = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else if (start_det) begin
      baud_cnt <= HALF_LOAD;
      bit_cnt  <= '0;
    end else if (sample) begin
      baud_cnt <= BIT_LOAD;
      bit_cnt  <= bit_cnt + 4'd1;
      if (bit_cnt != 4'd0 && bit_cnt <= 4'd8) begin
        shift <= {rx_sync, shift[7:1]};
      end
    end else if (state == RECEIVE) begin
      baud_cnt <= baud_cnt - 12'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data   <= '0;
      frame_err <= 1'b0;
      rdy       <= 1'b0;
    end else if (frame_done) begin
      rx_data   <= shift;
      frame_err <= ~rx_sync;
      rdy       <= 1'b1;
    end else if (clr_rdy || start_det) begin
      rdy <= 1'b0;
    end
  end

endmodule
